vga_framebuffer_reader: RTL and testbench

Read side of the video memory: the CPU fills the 32x32x3 cell framebuffer through `WVM`, and this block scans it back out. It generates 640x480@60 VGA timing from the 50 MHz system clock using a 2-cycle pixel tick. It fetches each pixel's cell colour through the framebuffer read port, which has one cycle of synchronous latency. It drives sync, RGB and pixel coordinates, all aligned to the same pixel.

---
 rtl/vga_framebuffer_reader_pkg.sv | 50 +++++
 rtl/vga_timing_counter.sv | 68 ++++++
 rtl/vga_framebuffer_reader.sv | 125 ++++++++++++
 tb/tb_vga_framebuffer_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_framebuffer_reader_pkg.sv
// Shared 640x480@60 timing constants, sync polarity, cell geometry and pixel record
// for the framebuffer scan-out path.
package vga_framebuffer_reader_pkg;

    localparam int unsigned H_ACTIVE_PX = 640;
    localparam int unsigned H_FP_PX     = 16;
    localparam int unsigned H_SYNC_PX   = 96;
    localparam int unsigned H_BP_PX     = 48;
    localparam int unsigned H_TOTAL_PX  = H_ACTIVE_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;

    localparam int unsigned V_ACTIVE_LN = 480;
    localparam int unsigned V_FP_LN     = 10;
    localparam int unsigned V_SYNC_LN   = 2;
    localparam int unsigned V_BP_LN     = 33;
    localparam int unsigned V_TOTAL_LN  = V_ACTIVE_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;

    localparam logic SYNC_LEVEL = 1'b0;

    localparam int unsigned CELL_SHIFT_X_DEF = 5;
    localparam int unsigned CELL_SHIFT_Y_DEF = 4;
    localparam int unsigned COLOR_W_DEF      = 3;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       active;
        logic       hSync;
        logic       vSync;
    } pixelInfo_t;

    localparam pixelInfo_t PIXEL_RESET = '{
        col:    10'd0,
        row:    10'd0,
        active: 1'b0,
        hSync:  ~SYNC_LEVEL,
        vSync:  ~SYNC_LEVEL
    };

    // Cell index {row cell, column cell}, 5 bits each.
    function automatic logic [9:0] cellAddress(input logic [9:0] col, input logic [9:0] row,
                                               input int unsigned shiftX,
                                               input int unsigned shiftY);
        logic [9:0] cellX;
        logic [9:0] cellY;
        cellX = col >> shiftX;
        cellY = row >> shiftY;
        return {cellY[4:0], cellX[4:0]};
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Stage 0 of the scan-out: pixel tick, column/row counters and the visibility and
// sync decode for the pixel currently addressed.
module vga_timing_counter
    import vga_framebuffer_reader_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_PX,
    parameter int unsigned H_FP     = H_FP_PX,
    parameter int unsigned H_SYNC   = H_SYNC_PX,
    parameter int unsigned H_BP     = H_BP_PX,
    parameter int unsigned V_ACTIVE = V_ACTIVE_LN,
    parameter int unsigned V_FP     = V_FP_LN,
    parameter int unsigned V_SYNC   = V_SYNC_LN,
    parameter int unsigned V_BP     = V_BP_LN
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iEnable,
    output logic       oTick,
    output pixelInfo_t oPixel
);

    localparam logic [9:0] HActive    = 10'(H_ACTIVE);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] HLast      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VActive    = 10'(V_ACTIVE);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic       tickQ;
    logic [9:0] colQ;
    logic [9:0] rowQ;

    // Tick is high on every second enabled Clock, starting with the second one.
    assign oTick = tickQ & iEnable;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tickQ <= 1'b0;
        end else if (iEnable) begin
            tickQ <= ~tickQ;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            colQ <= 10'd0;
            rowQ <= 10'd0;
        end else if (oTick) begin
            if (colQ == HLast) begin
                colQ <= 10'd0;
                rowQ <= (rowQ == VLast) ? 10'd0 : rowQ + 10'd1;
            end else begin
                colQ <= colQ + 10'd1;
            end
        end
    end

    always_comb begin
        oPixel.col    = colQ;
        oPixel.row    = rowQ;
        oPixel.active = (colQ < HActive) && (rowQ < VActive);
        oPixel.hSync  = (colQ >= HSyncStart && colQ < HSyncEnd) ? SYNC_LEVEL : ~SYNC_LEVEL;
        oPixel.vSync  = (rowQ >= VSyncStart && rowQ < VSyncEnd) ? SYNC_LEVEL : ~SYNC_LEVEL;
    end

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Framebuffer scan-out: issues cell read addresses and aligns RAM data, syncs and counts
// to the same output pixel. Optional white frame around the visible area: FB_BORDER_EN.
module vga_framebuffer_reader
    import vga_framebuffer_reader_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_PX,
    parameter int unsigned H_FP         = H_FP_PX,
    parameter int unsigned H_SYNC       = H_SYNC_PX,
    parameter int unsigned H_BP         = H_BP_PX,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_LN,
    parameter int unsigned V_FP         = V_FP_LN,
    parameter int unsigned V_SYNC       = V_SYNC_LN,
    parameter int unsigned V_BP         = V_BP_LN,
    parameter int unsigned CELL_SHIFT_X = CELL_SHIFT_X_DEF,
    parameter int unsigned CELL_SHIFT_Y = CELL_SHIFT_Y_DEF,
    parameter int unsigned COLOR_W      = COLOR_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    output logic [9:0]         oReadAddress,
    input  logic [COLOR_W-1:0] iReadData,
    output logic               oHorizontalSync,
    output logic               oVerticalSync,
    output logic               oRed,
    output logic               oGreen,
    output logic               oBlue,
    output logic [9:0]         oColumnCount,
    output logic [9:0]         oRowCount,
    output logic               oActive,
    output logic               oFrameStart
);

    logic       tick;
    pixelInfo_t stage0;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) timing (
        .Clock   (Clock),
        .Reset   (Reset),
        .iEnable (iEnable),
        .oTick   (tick),
        .oPixel  (stage0)
    );

    logic [9:0]         addressQ;
    pixelInfo_t         pipeQ;
    logic               pipeValidQ;
    logic [COLOR_W-1:0] colorQ;
    logic               hSyncQ;
    logic               vSyncQ;
    logic               activeQ;
    logic [9:0]         columnQ;
    logic [9:0]         rowQ;
    logic               frameStartQ;
    logic [COLOR_W-1:0] pixelColor;

`ifdef FB_BORDER_EN
    localparam logic [9:0] HLastActive = 10'(H_ACTIVE - 1);
    localparam logic [9:0] VLastActive = 10'(V_ACTIVE - 1);

    always_comb begin
        pixelColor = iReadData;
        if (pipeQ.col == 10'd0 || pipeQ.col == HLastActive ||
            pipeQ.row == 10'd0 || pipeQ.row == VLastActive) begin
            pixelColor = '1;
        end
    end
`else
    always_comb begin
        pixelColor = iReadData;
    end
`endif

    // The address is held across the whole pixel, so RAM data issued on one tick is
    // settled by the next tick and is sampled there together with the delayed pixel.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            addressQ    <= 10'd0;
            pipeQ       <= PIXEL_RESET;
            pipeValidQ  <= 1'b0;
            colorQ      <= '0;
            hSyncQ      <= ~SYNC_LEVEL;
            vSyncQ      <= ~SYNC_LEVEL;
            activeQ     <= 1'b0;
            columnQ     <= 10'd0;
            rowQ        <= 10'd0;
            frameStartQ <= 1'b0;
        end else begin
            frameStartQ <= 1'b0;
            if (tick) begin
                addressQ    <= cellAddress(stage0.col, stage0.row, CELL_SHIFT_X, CELL_SHIFT_Y);
                pipeQ       <= stage0;
                pipeValidQ  <= 1'b1;
                colorQ      <= pipeQ.active ? pixelColor : '0;
                hSyncQ      <= pipeQ.hSync;
                vSyncQ      <= pipeQ.vSync;
                activeQ     <= pipeQ.active;
                columnQ     <= pipeQ.col;
                rowQ        <= pipeQ.row;
                frameStartQ <= pipeValidQ && pipeQ.col == 10'd0 && pipeQ.row == 10'd0;
            end
        end
    end

    assign oReadAddress    = addressQ;
    assign oHorizontalSync = hSyncQ;
    assign oVerticalSync   = vSyncQ;
    assign oRed            = colorQ[2];
    assign oGreen          = colorQ[1];
    assign oBlue           = colorQ[0];
    assign oColumnCount    = columnQ;
    assign oRowCount       = rowQ;
    assign oActive         = activeQ;
    assign oFrameStart     = frameStartQ;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench for vga_framebuffer_reader: a full-size and a shrunken-timing instance checked
// every Clock against a pixel-index reference model with random memory and enable gaps.
module tb_vga_framebuffer_reader;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic [9:0] addr;
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [2:0] rgb;
    } expT;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic iEnable = 1'b0;

    logic [9:0] addrM, colM, rowM, addrS, colS, rowS;
    logic [2:0] ramM, ramS;
    logic hsM, vsM, rM, gM, bM, actM, fsM;
    logic hsS, vsS, rS, gS, bS, actS, fsS;

    logic [2:0] mem [1024];

    int unsigned nClk;
    bit          lastTick;
    int          assertCount = 0;
    int          failCount = 0;

    vga_framebuffer_reader dutMain (
        .Clock (Clock), .Reset (Reset), .iEnable (iEnable),
        .oReadAddress (addrM), .iReadData (ramM),
        .oHorizontalSync (hsM), .oVerticalSync (vsM),
        .oRed (rM), .oGreen (gM), .oBlue (bM),
        .oColumnCount (colM), .oRowCount (rowM),
        .oActive (actM), .oFrameStart (fsM)
    );

    vga_framebuffer_reader #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dutSmall (
        .Clock (Clock), .Reset (Reset), .iEnable (iEnable),
        .oReadAddress (addrS), .iReadData (ramS),
        .oHorizontalSync (hsS), .oVerticalSync (vsS),
        .oRed (rS), .oGreen (gS), .oBlue (bS),
        .oColumnCount (colS), .oRowCount (rowS),
        .oActive (actS), .oFrameStart (fsS)
    );

    always #10 Clock = ~Clock;

    // Synchronous RAMs with one Clock of read latency.
    always @(posedge Clock) ramM <= mem[addrM];
    always @(posedge Clock) ramS <= mem[addrS];

    function automatic int cellOf(input int c, input int r);
        return ((r >> 4) & 31) * 32 + ((c >> 5) & 31);
    endfunction

    // Output pixel after n enabled Clocks: tick k = n/2, address shows pixel k-1,
    // outputs show pixel k-2.
    function automatic expT model(input int unsigned n, input bit tk,
                                  input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb);
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int k = int'(n / 2);
        int c, r;
        expT e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (k >= 1) begin
            c = (k - 1) % ht;
            r = ((k - 1) / ht) % vt;
            e.addr = 10'(cellOf(c, r));
        end
        if (k >= 2) begin
            c = (k - 2) % ht;
            r = ((k - 2) / ht) % vt;
            e.col = 10'(c);
            e.row = 10'(r);
            e.act = (c < ha) && (r < va);
            e.hs = !(c >= ha + hf && c < ha + hf + hsw);
            e.vs = !(r >= va + vf && r < va + vf + vsw);
            e.fs = tk && c == 0 && r == 0;
            if (e.act) begin
                e.rgb = mem[cellOf(c, r)];
`ifdef FB_BORDER_EN
                if (c == 0 || c == ha - 1 || r == 0 || r == va - 1) e.rgb = 3'b111;
`endif
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkInst(input string name, input expT e,
                             input logic [9:0] col, input logic [9:0] row,
                             input logic [9:0] addr, input logic hs, input logic vs,
                             input logic act, input logic fs, input logic [2:0] rgb);
        check({name, ".col"}, 16'(col), 16'(e.col));
        check({name, ".row"}, 16'(row), 16'(e.row));
        check({name, ".addr"}, 16'(addr), 16'(e.addr));
        check({name, ".hsync"}, 16'(hs), 16'(e.hs));
        check({name, ".vsync"}, 16'(vs), 16'(e.vs));
        check({name, ".active"}, 16'(act), 16'(e.act));
        check({name, ".frameStart"}, 16'(fs), 16'(e.fs));
        check({name, ".rgb"}, 16'(rgb), 16'(e.rgb));
    endtask

    task automatic checkAll();
        checkInst("main", model(nClk, lastTick, 640, 16, 96, 48, 480, 10, 2, 33),
                  colM, rowM, addrM, hsM, vsM, actM, fsM, {rM, gM, bM});
        checkInst("small", model(nClk, lastTick, 64, 4, 8, 4, 6, 1, 2, 1),
                  colS, rowS, addrS, hsS, vsS, actS, fsS, {rS, gS, bS});
    endtask

    task automatic step();
        @(posedge Clock);
        if (Reset) begin
            nClk = 0;
            lastTick = 1'b0;
        end else if (iEnable) begin
            nClk++;
            lastTick = (nClk % 2 == 0);
        end else begin
            lastTick = 1'b0;
        end
        @(negedge Clock);
        checkAll();
    endtask

    task automatic run(input int count, input bit randomEnable);
        for (int i = 0; i < count; i++) begin
            iEnable = randomEnable ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
        end
    endtask

    task automatic seek(input int unsigned target);
        int guard = 0;
        iEnable = 1'b1;
        while (nClk != target && guard < 40000) begin
            step();
            guard++;
        end
        check("seek.reached", 16'(nClk == target), 16'd1);
    endtask

    initial begin
        logic [2:0] cell33;
        for (int i = 0; i < 1024; i++) mem[i] = 3'($urandom_range(0, 7));
        cell33 = mem[33];
        nClk = 0;
        lastTick = 1'b0;
        Reset = 1'b1;
        iEnable = 1'b0;
        repeat (3) step();

        Reset = 1'b0;
        iEnable = 1'b1;
        repeat (3) step();
        step();
        check("frameStart.clock4", 16'(fsM), 16'd1);
        step();
        check("frameStart.clock5", 16'(fsM), 16'd0);

        run(3400, 1'b0);
        run(4000, 1'b1);

        // Address for (40,20) is issued, then the pixel reaches the outputs.
        seek(2 * (20 * 800 + 40 + 1));
        check("addr.col40row20", 16'(addrM), 16'd33);
        seek(nClk + 2);
        check("out.col40", 16'(colM), 16'd40);
        check("out.row20", 16'(rowM), 16'd20);
        check("out.rgb40_20", 16'({rM, gM, bM}), 16'(cell33));

        seek(2 * (20 * 800 + 300 + 2));
        iEnable = 1'b0;
        repeat (100) step();
        check("freeze.col", 16'(colM), 16'd300);
        iEnable = 1'b1;
        step();
        step();
        check("resume.col", 16'(colM), 16'd301);

        seek(2 * (20 * 800 + 500 + 2));
        Reset = 1'b1;
        #1;
        nClk = 0;
        lastTick = 1'b0;
        checkAll();
        check("reset.midline.col", 16'(colM), 16'd0);
        check("reset.midline.hsync", 16'(hsM), 16'd1);
        repeat (2) step();
        Reset = 1'b0;
        run(2000, 1'b1);
        run(1200, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
